program_loader: RTL
===================

# program_loader

Byte-stream boot loader that sits in front of `pipelined_RISC`, doing the fill the core otherwise gets from hierarchical pokes. It writes instruction memory and data memory through their byte write ports. It sets the fetch start address, and holds the core's `start` high during loading. A GO command drops `start`, which releases the core to run.

## Interface
- `ADDR_W`, 10: byte-address width of each memory. Addresses wrap modulo 2^ADDR_W.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  command/payload byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle. Transfer happens when valid && ready.
- `imem_we`  out  1  instruction-memory byte write strobe.
- `dmem_we`  out  1  data-memory byte write strobe.
- `mem_addr`  out  ADDR_W  byte address, shared by both memories.
- `mem_wdata`  out  8  write byte, shared by both memories.
- `start_address`  out  32  initial PC for the fetch stage.
- `cpu_start`  out  1  drives core `start`. 1 = hold/load, 0 = run.
- `busy`  out  1  a frame is in progress.
- `err`  out  1  sticky error flag. Cleared by `rst` or by the R command.

## Operation
- Frame format: command byte, then its operands. All multi-byte fields are little-endian.
  - `0x49` ('I'): addr[15:0], cnt[15:0], then cnt bytes written to instruction memory.
  - `0x44` ('D'): same layout as 'I', written to data memory.
  - `0x47` ('G'): 4 bytes forming `start_address`, then `cpu_start` goes to 0.
  - `0x52` ('R'): reload. Allowed only in RUN.
- FSM states: IDLE, ADDR0, ADDR1, CNT0, CNT1, PAYLOAD, GOADR (4-byte counter), RUN.
  - IDLE, 'I' or 'D': latch the target, go to ADDR0.
  - IDLE, 'G': go to GOADR.
  - IDLE, any other byte: discard it, set `err`, stay in IDLE.
  - ADDR0 → ADDR1 → CNT0 → CNT1.
  - CNT1 → PAYLOAD. If cnt == 0, go to IDLE instead; no writes occur.
  - PAYLOAD: each accepted byte writes at the current address, then the address increments and cnt decrements. After the byte where cnt reaches 0, go to IDLE.
  - GOADR: after the 4th byte, update `start_address`, set `cpu_start` = 0, go to RUN.
  - RUN, 0x52: set `cpu_start` = 1, clear `err`, go to IDLE.
  - RUN, any other byte: discard it, set `err`.
- Only ADDR_W low bits of addr are used. The address wraps from 2^ADDR_W−1 to 0 within a payload.
- `in_ready` = 1 in every state. The loader never stalls, because a memory write takes one cycle.
- `busy` = 1 in every state except IDLE and RUN.

## Timing
- Reset values:
  - state = IDLE.
  - `imem_we` = `dmem_we` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0.
  - `start_address` = 0.
  - `cpu_start` = 1.
  - `busy` = 0, `err` = 0.
- Write outputs are registered. A payload byte accepted at edge N appears as we/addr/data for the cycle after N (latency 1). The strobe lasts exactly one cycle per byte.
- Back-to-back valid payload bytes produce one write per cycle with consecutive addresses.
- A gap in `in_valid` inserts a cycle with no write. State and counters hold during the gap.
- `start_address` and `cpu_start` = 0 update together, on the same edge that accepts the 4th GO byte.
- A following frame may start on the cycle immediately after the last byte of the previous frame.
- `rst` mid-frame aborts the frame. Writes already issued stay in memory. The next cycle is in the reset state.

## Structure
- Package `loader_pkg`:
  - command byte constants `CMD_I`, `CMD_D`, `CMD_G`, `CMD_R`.
  - state enum.
- Single module; no sub-module needed. The 16-bit address counter and 16-bit byte counter are inline registers.
- Integration: the top level instantiates `program_loader` beside `pipelined_RISC`.
  - `cpu_start` → core `start`.
  - `start_address` → fetch start address.
  - `imem_we`/`dmem_we` with shared addr/data → write ports of the fetch and memory stages.

## Test plan
- Reset state: hold `rst` 2 cycles → all outputs at their reset values, including `cpu_start` = 1 and `in_ready` = 1.
- Instruction load: 'I' 00 00 04 00, then 00 00 03 8C → `imem_we` pulses 4 cycles with addr 0..3 and data 00,00,03,8C. A following `dmem` load of 0A 00 00 00 at addr 0 and 09 00 00 00 at addr 4 writes data memory only. After both loads, the core reads word 0 = 0x8C030000.
- Go and run: 'G' 00 00 00 00 → `start_address` = 0 and `cpu_start` falls on the same edge as the 4th operand byte. The core then executes the loaded program, with lw results visible in the register file.
- Flow control and wrap: 'D' FE 03 03 00 with `in_valid` toggling every other cycle → 3 writes to 0x3FE, 0x3FF, 0x000, each spaced by the valid gaps. 'D' with cnt = 0 → no writes, and busy returns to 0.
- Errors: byte 0x55 in IDLE → `err` = 1, state stays IDLE. In RUN, 0x52 → `err` = 0 and `cpu_start` = 1.
- Reset mid-frame: `rst` after 2 of 5 payload bytes → only 2 writes issued, state IDLE, counters cleared.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream boot loader: command bytes and FSM states.
package loader_pkg;

  // Command bytes (ASCII 'I', 'D', 'G', 'R')
  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_R = 8'h52;

  // Frame parser states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR0   = 3'd1,
    ST_ADDR1   = 3'd2,
    ST_CNT0    = 3'd3,
    ST_CNT1    = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_GOADR   = 3'd6,
    ST_RUN     = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream boot loader: parses I/D/G/R frames, writes instruction or data
// memory one byte per accepted payload byte, and holds the core in reset-like
// "start" until a GO frame supplies the initial PC.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10  // byte-address width; the 16-bit frame address is truncated to this
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [31:0]       start_address,
  output logic              cpu_start,
  output logic              busy,
  output logic              err
);

  state_t            state_reg;
  logic              is_dmem_reg;   // target of the current I/D frame
  logic [ADDR_W-1:0] addr_reg;      // only the low ADDR_W bits of addr[15:0] matter; wraps naturally
  logic [15:0]       cnt_reg;       // bytes remaining in the payload
  logic [1:0]        go_cnt_reg;    // GO operand byte index
  logic [23:0]       go_shift_reg;  // first three GO bytes, little-endian

  // Every memory write takes one cycle, so the loader never needs to stall
  assign in_ready = 1'b1;

  // A frame is in progress whenever the parser is between IDLE and RUN
  assign busy = (state_reg != ST_IDLE) && (state_reg != ST_RUN);

  // Frame parser with registered memory-write and core-control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      is_dmem_reg   <= 1'b0;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      go_cnt_reg    <= '0;
      go_shift_reg  <= '0;
      imem_we       <= 1'b0;
      dmem_we       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      start_address <= '0;
      cpu_start     <= 1'b1;
      err           <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are re-raised only by an accepted payload byte
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (in_valid) begin
        case (state_reg)
          ST_IDLE: begin
            case (in_data)
              CMD_I: begin
                is_dmem_reg <= 1'b0;
                state_reg   <= ST_ADDR0;
              end
              CMD_D: begin
                is_dmem_reg <= 1'b1;
                state_reg   <= ST_ADDR0;
              end
              CMD_G: begin
                go_cnt_reg <= '0;
                state_reg  <= ST_GOADR;
              end
              default: err <= 1'b1;  // unknown byte (including R outside RUN) is dropped
            endcase
          end
          ST_ADDR0: begin
            addr_reg[7:0] <= in_data;
            state_reg     <= ST_ADDR1;
          end
          ST_ADDR1: begin
            // Upper address bits beyond ADDR_W are discarded
            addr_reg[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
            state_reg            <= ST_CNT0;
          end
          ST_CNT0: begin
            cnt_reg[7:0] <= in_data;
            state_reg    <= ST_CNT1;
          end
          ST_CNT1: begin
            cnt_reg[15:8] <= in_data;
            // An empty payload ends the frame without any writes
            if ({in_data, cnt_reg[7:0]} == 16'd0) state_reg <= ST_IDLE;
            else                                  state_reg <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            imem_we   <= ~is_dmem_reg;
            dmem_we   <= is_dmem_reg;
            mem_addr  <= addr_reg;
            mem_wdata <= in_data;
            addr_reg  <= addr_reg + 1'b1;
            cnt_reg   <= cnt_reg - 16'd1;
            if (cnt_reg == 16'd1) state_reg <= ST_IDLE;
          end
          ST_GOADR: begin
            go_cnt_reg <= go_cnt_reg + 2'd1;
            if (go_cnt_reg == 2'd3) begin
              // PC and release of the core change on the same edge
              start_address <= {in_data, go_shift_reg};
              cpu_start     <= 1'b0;
              state_reg     <= ST_RUN;
            end else begin
              go_shift_reg <= {in_data, go_shift_reg[23:8]};
            end
          end
          ST_RUN: begin
            if (in_data == CMD_R) begin
              cpu_start <= 1'b1;
              err       <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              err <= 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
